// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: round-robin sharing of one single-port RAM between NCORES cores.
// Optional hold mode (repeat grants to the previous owner up to MAX_HOLD times)
// is compiled in with `define SHARED_RAM_ARB_HOLD_EN.
module shared_ram_arbiter #(
    parameter int NCORES   = 4,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NCORES-1:0]          i_req,
    input  logic [NCORES-1:0]          i_we,
    input  logic [NCORES*AW-1:0]       i_addr,
    input  logic [NCORES*DW-1:0]       i_wdata,
    output logic [NCORES-1:0]          o_ack,
    output logic [DW-1:0]              o_rdata,
    output logic                       o_busy,
    output logic [$clog2(NCORES)-1:0]  o_grant_id,
    output logic [AW-1:0]              o_ram_addr,
    output logic [DW-1:0]              o_ram_din,
    output logic                       o_ram_wren,
    input  logic [DW-1:0]              i_ram_q
);
    localparam int IW = $clog2(NCORES);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t        r_state, w_next;
    logic [IW-1:0] r_ptr, r_grant, w_rr, w_win, w_idx;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din, r_rdata;
    logic          r_wren;
`ifdef SHARED_RAM_ARB_HOLD_EN
    logic [3:0]    r_hold;
    logic          w_keep;
`endif

    // Round-robin search upward from ptr+1; iterating downward leaves the nearest requester.
    always_comb begin
        w_rr  = r_ptr;
        w_idx = '0;
        for (int k = NCORES; k >= 1; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NCORES);
            if (i_req[w_idx]) w_rr = w_idx;
        end
    end

`ifdef SHARED_RAM_ARB_HOLD_EN
    // hold_cnt of 0 means no previous owner yet, so the first grant is pure round-robin
    assign w_keep = (r_hold != 4'd0) && (r_hold < 4'(MAX_HOLD)) && i_req[r_ptr];
    assign w_win  = w_keep ? r_ptr : w_rr;
`else
    assign w_win  = w_rr;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state: writes skip WAIT, reads wait out the RAM latency
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = |i_req ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = r_wren ? S_ACK : S_WAIT;
            S_WAIT:  w_next = (r_cnt == 2'd1) ? S_ACK : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state: one-hot ack to the owner, busy outside IDLE
    always_comb begin
        o_ack  = (r_state == S_ACK) ? NCORES'(1) << r_grant : '0;
        o_busy = r_state != S_IDLE;
    end

    // Datapath: latch the winner's request, time the read, capture read data
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= IW'(NCORES - 1);
            r_grant <= '0;
            r_addr  <= '0;
            r_din   <= '0;
            r_wren  <= 1'b0;
            r_rdata <= '0;
            r_cnt   <= '0;
`ifdef SHARED_RAM_ARB_HOLD_EN
            r_hold  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (|i_req) begin
                    r_addr  <= i_addr[w_win*AW +: AW];
                    r_din   <= i_wdata[w_win*DW +: DW];
                    r_wren  <= i_we[w_win];
                    r_grant <= w_win;
                    r_ptr   <= w_win;
`ifdef SHARED_RAM_ARB_HOLD_EN
                    r_hold  <= w_keep ? r_hold + 4'd1 : 4'd1;
`endif
                end
                S_ISSUE: begin
                    r_wren <= 1'b0;
                    r_cnt  <= 2'(RD_LAT);
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) r_rdata <= i_ram_q;
                end
                default: ;
            endcase
        end
    end

    assign o_rdata    = r_rdata;
    assign o_grant_id = r_grant;
    assign o_ram_addr = r_addr;
    assign o_ram_din  = r_din;
    assign o_ram_wren = r_wren;
endmodule

// File: doc/shared_ram_arbiter.md
# shared_ram_arbiter

- Round-robin arbiter and sequencer that lets `NCORES` processor cores share one single-port 8-bit RAM.
- Each core has a private request/ack port and a private address/data bus. Only the granted core's request is presented to the RAM.
- Read data is captured and broadcast; completion is signalled by a one-cycle `ack` pulse to the owner.
- Sits between the core array and the shared data RAM, and replaces direct core-to-RAM wiring.

## Interface
- `NCORES`, 4, number of requesting cores (2..8).
- `AW`, 8, RAM address width.
- `DW`, 8, RAM data width.
- `RD_LAT`, 1, RAM read latency in clocks from the edge that samples the address to valid `ram_q` (1..3).
- `MAX_HOLD`, 4, maximum consecutive grants to one core when hold mode is compiled in (1..15).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NCORES  per-core transaction request; held high until `ack`.
- `we`  in  NCORES  per-core write enable; 1 = write, 0 = read; valid while `req` is high.
- `addr`  in  NCORES*AW  per-core address; core i uses bits [i*AW +: AW].
- `wdata`  in  NCORES*DW  per-core write data; same slicing as `addr`.
- `ack`  out  NCORES  one-cycle completion pulse to the granted core.
- `rdata`  out  DW  read data; valid in the `ack` cycle and held until the next read completes.
- `busy`  out  1  high while a transaction is in flight (any state other than IDLE).
- `grant_id`  out  $clog2(NCORES)  index of the current or last granted core.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_wren`  out  1  RAM write enable.
- `ram_q`  in  DW  RAM read data.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, ACK.
- **IDLE**
  - If no `req` bit is set, stay in IDLE.
  - Otherwise select a winner: search upward from `ptr+1`, wrapping modulo NCORES; the first core with `req` high wins.
  - On the grant edge:
    - latch that core's `addr`, `wdata` and `we` into `ram_addr`, `ram_din`, `ram_wren`;
    - set `grant_id` to the winner and `ptr` to the winner;
    - go to ISSUE.
- **ISSUE**
  - Write: clear `ram_wren` and go to ACK.
  - Read: load the latency counter with `RD_LAT` and go to WAIT.
- **WAIT**
  - Decrement the latency counter each cycle.
  - When the counter reaches 1, capture `ram_q` into `rdata` and go to ACK.
- **ACK**
  - `ack[grant_id]` is high for exactly this one cycle; then go to IDLE.
  - Requests are not sampled in ACK. The requester may drop `req`, or change `addr`/`we` and keep `req` high, at the edge ending ACK.
- **Boundary conditions**
  - `req` dropped by the owner mid-transaction: the transaction still completes and `ack` still pulses.
  - `req`, `we`, `addr` and `wdata` of non-granted cores are ignored until the next IDLE.
  - `ram_wren` is high for exactly one cycle per write and never during a read.
  - `rdata` is not updated by writes.
- **Reset values:** `ack`=0, `rdata`=0, `busy`=0, `grant_id`=0, `ram_addr`=0, `ram_din`=0, `ram_wren`=0, `ptr`=NCORES-1 (so core 0 wins first), state=IDLE.
- **Reset mid-transaction:** the transaction is abandoned, `ram_wren` drops immediately (asynchronously), and no `ack` is issued.

## Timing
- E0 is the IDLE edge at which `req` is sampled.
- After E0: `ram_*` outputs are valid and `busy`=1.
- Write:
  - the RAM samples at E1;
  - `ack` is high between E2 and E3;
  - back in IDLE after E3;
  - next grant no earlier than E3.
- Read:
  - `rdata` is captured at E(RD_LAT+1);
  - `ack` is high for the cycle after that edge;
  - with `RD_LAT`=1, `ack` is high between E2 and E3.
- Peak throughput: one write per 3 cycles; one read per RD_LAT+3 cycles.
- `busy` falls at the edge that ends ACK.

## Configuration
- `SHARED_RAM_ARB_HOLD_EN` defined:
  - In IDLE, if the previous owner `ptr` still has `req` high and `hold_cnt < MAX_HOLD`, that owner wins again and `hold_cnt` increments.
  - Otherwise normal round-robin applies and `hold_cnt` is set to 1 for the new owner.
  - `hold_cnt` resets to 0.
- `SHARED_RAM_ARB_HOLD_EN` not defined:
  - Pure round-robin; the previous owner always has lowest priority.
  - No `hold_cnt` register exists.

## Test plan
- **Reset and single write:** after reset, core 2 requests a write of 0xA5 to 0x10 → `ram_wren`=1 for one cycle with `ram_addr`=0x10 and `ram_din`=0xA5, `grant_id`=2, `ack[2]` high two cycles after the grant.
- **Single read:** core 1 reads 0x10, RAM model returns 0xA5 with `RD_LAT`=1 → `rdata`=0xA5 while `ack[1]`=1, exactly one `ack` pulse, `ram_wren` never high.
- **Contention rotation:** all four cores hold `req` from reset → grant order 0,1,2,3,0,… (hold mode off).
- **Hold mode:** with `SHARED_RAM_ARB_HOLD_EN` and `MAX_HOLD`=4, all cores requesting → grant order 0,0,0,0,1,1,1,1,2,…
- **Abandoned request:** core 3 drops `req` in ISSUE → transaction completes and `ack[3]` still pulses; other cores' `ack` bits stay 0.
- **Reset mid-write:** `rst_n` asserted in ISSUE with `ram_wren`=1 → `ram_wren`=0 immediately, no `ack`, core 0 granted first after release.
